mult_acc_stream: RTL and testbench



---
 rtl/mult_acc_stream.sv | 177 +++++++++++++++++
 tb/tb_mult_acc_stream.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_acc_stream.sv
// mult_acc_stream
// Streaming multiply-accumulate. Each accepted beat multiplies a by b through
// a LATENCY-deep register pipeline and adds the product into a packet
// accumulator. The beat flagged i_last emits the packet sum together with a
// sticky overflow flag.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   arst       - asynchronous active-high reset
//   i_valid    - input beat valid
//   i_ready    - block can accept a beat (combinational from o_ready/o_valid)
//   a, b       - operands
//   i_last     - beat is the final beat of its packet
//   o_valid    - packet result valid
//   o_ready    - consumer accepts the result
//   o          - packet sum, ACC_WIDTH bits, wraps modulo 2^ACC_WIDTH
//   o_overflow - the packet sum overflowed ACC_WIDTH, qualified by o_valid
module mult_acc_stream #(
    parameter int    A_WIDTH   = 8,
    parameter int    B_WIDTH   = 8,
    parameter string A_SIGNED  = "FALSE",
    parameter string B_SIGNED  = "FALSE",
    parameter int    LATENCY   = 2,
    parameter int    ACC_WIDTH = A_WIDTH + B_WIDTH + 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [ACC_WIDTH-1:0] o,
    output logic                 o_overflow
);

    localparam bit A_S   = (A_SIGNED == "TRUE");
    localparam bit B_S   = (B_SIGNED == "TRUE");
    localparam bit RES_S = A_S || B_S;
    localparam int PW    = A_WIDTH + B_WIDTH;

    logic                 w_en;
    logic                 r_o_valid;
    logic [ACC_WIDTH-1:0] r_o;
    logic                 r_o_ovf;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;

    // Whole pipeline freezes while a result is waiting for the consumer.
    assign w_en    = !r_o_valid || o_ready;
    assign i_ready = w_en;

    // Each operand gets one extra bit so every mode becomes a signed multiply:
    // unsigned operands are zero-extended, signed ones sign-extended.
    logic signed [A_WIDTH:0] w_a_ext;
    logic signed [B_WIDTH:0] w_b_ext;
    logic signed [A_WIDTH:0] r_a;
    logic signed [B_WIDTH:0] r_b;
    logic                    r_v1;
    logic                    r_l1;

    assign w_a_ext = A_S ? {a[A_WIDTH-1], a} : {1'b0, a};
    assign w_b_ext = B_S ? {b[B_WIDTH-1], b} : {1'b0, b};

    // Stage 1: operand register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
        end else if (w_en) begin
            r_a  <= w_a_ext;
            r_b  <= w_b_ext;
            r_v1 <= i_valid;
            r_l1 <= i_last;
        end
    end

    // The true product always fits in PW bits, so multiplying at PW bits
    // (which keeps only the low PW bits) is exact.
    logic signed [PW-1:0] w_a_wide;
    logic signed [PW-1:0] w_b_wide;
    logic signed [PW-1:0] w_mult;

    assign w_a_wide = PW'(r_a);
    assign w_b_wide = PW'(r_b);
    assign w_mult   = w_a_wide * w_b_wide;

    // Stage outputs: index gi is what stage gi presents to the next stage.
    logic [LATENCY:1] w_v;
    logic [LATENCY:1] w_l;
    logic [PW-1:0]    w_sp [1:LATENCY];

    genvar gi;
    generate
        for (gi = 1; gi <= LATENCY; gi++) begin : g_stage
            if (gi == 1) begin : g_first
                assign w_v[gi]  = r_v1;
                assign w_l[gi]  = r_l1;
                assign w_sp[gi] = w_mult;
            end else begin : g_reg
                logic          r_v;
                logic          r_l;
                logic [PW-1:0] r_p;
                always_ff @(posedge clk or posedge arst) begin
                    if (arst) begin
                        r_v <= 1'b0;
                        r_l <= 1'b0;
                        r_p <= '0;
                    end else if (w_en) begin
                        r_v <= w_v[gi-1];
                        r_l <= w_l[gi-1];
                        r_p <= w_sp[gi-1];
                    end
                end
                assign w_v[gi]  = r_v;
                assign w_l[gi]  = r_l;
                assign w_sp[gi] = r_p;
            end
        end
    endgenerate

    logic                 w_fv;
    logic                 w_fl;
    logic signed [PW:0]   w_px;
    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf;

    assign w_fv = w_v[LATENCY];
    assign w_fl = w_l[LATENCY];

    // Extend the product by one bit per result mode, then the signed size cast
    // replicates that top bit up to ACC_WIDTH.
    assign w_px  = RES_S ? {w_sp[LATENCY][PW-1], w_sp[LATENCY]} : {1'b0, w_sp[LATENCY]};
    assign w_ext = ACC_WIDTH'(w_px);
    assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

    // Signed: addends agree in sign but the result does not.
    // Unsigned: carry out of the top accumulator bit.
    assign w_ovf = RES_S ? ((r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                            (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]))
                         : w_sum[ACC_WIDTH];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_o       <= '0;
            r_o_ovf   <= 1'b0;
            r_o_valid <= 1'b0;
        end else if (w_en) begin
            // A pending result is consumed on this edge (or none was pending);
            // o_valid stays high only if another packet completes right now.
            r_o_valid <= w_fv && w_fl;
            if (w_fv) begin
                if (w_fl) begin
                    r_o     <= w_sum[ACC_WIDTH-1:0];
                    r_o_ovf <= r_ovf | w_ovf;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                end else begin
                    r_acc   <= w_sum[ACC_WIDTH-1:0];
                    r_ovf   <= r_ovf | w_ovf;
                end
            end
        end
    end

    assign o_valid    = r_o_valid;
    assign o          = r_o;
    assign o_overflow = r_o_ovf;

endmodule

// File: tb/tb_mult_acc_stream.sv
// Testbench for mult_acc_stream. Five instances with different signedness and
// accumulator widths share one input stream; a reference model computes each
// packet's expected sum/overflow per instance and pushes it to a scoreboard
// queue when the last beat is accepted. A monitor pops and compares on every
// result handshake.
module tb_mult_acc_stream;

    logic       clk;
    logic       arst;
    logic       i_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       i_last;
    logic       o_ready;

    logic [4:0]  ir;
    logic [4:0]  ov;
    logic [4:0]  of;
    logic [23:0] o_0, o_1, o_2;
    logic [15:0] o_3, o_4;
    logic [23:0] obs_o [5];

    assign obs_o[0] = o_0;
    assign obs_o[1] = o_1;
    assign obs_o[2] = o_2;
    assign obs_o[3] = {8'd0, o_3};
    assign obs_o[4] = {8'd0, o_4};

    // 0: unsigned/unsigned ACC24   1: signed/signed ACC24   2: signed a, unsigned b ACC24
    // 3: unsigned/unsigned ACC16   4: unsigned a, signed b ACC16
    mult_acc_stream #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED("FALSE"), .B_SIGNED("FALSE"),
                      .LATENCY(2), .ACC_WIDTH(24)) u_uu24 (
        .clk(clk), .arst(arst), .i_valid(i_valid), .i_ready(ir[0]), .a(a), .b(b),
        .i_last(i_last), .o_valid(ov[0]), .o_ready(o_ready), .o(o_0), .o_overflow(of[0]));
    mult_acc_stream #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED("TRUE"), .B_SIGNED("TRUE"),
                      .LATENCY(2), .ACC_WIDTH(24)) u_ss24 (
        .clk(clk), .arst(arst), .i_valid(i_valid), .i_ready(ir[1]), .a(a), .b(b),
        .i_last(i_last), .o_valid(ov[1]), .o_ready(o_ready), .o(o_1), .o_overflow(of[1]));
    mult_acc_stream #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED("TRUE"), .B_SIGNED("FALSE"),
                      .LATENCY(2), .ACC_WIDTH(24)) u_su24 (
        .clk(clk), .arst(arst), .i_valid(i_valid), .i_ready(ir[2]), .a(a), .b(b),
        .i_last(i_last), .o_valid(ov[2]), .o_ready(o_ready), .o(o_2), .o_overflow(of[2]));
    mult_acc_stream #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED("FALSE"), .B_SIGNED("FALSE"),
                      .LATENCY(2), .ACC_WIDTH(16)) u_uu16 (
        .clk(clk), .arst(arst), .i_valid(i_valid), .i_ready(ir[3]), .a(a), .b(b),
        .i_last(i_last), .o_valid(ov[3]), .o_ready(o_ready), .o(o_3), .o_overflow(of[3]));
    mult_acc_stream #(.A_WIDTH(8), .B_WIDTH(8), .A_SIGNED("FALSE"), .B_SIGNED("TRUE"),
                      .LATENCY(2), .ACC_WIDTH(16)) u_us16 (
        .clk(clk), .arst(arst), .i_valid(i_valid), .i_ready(ir[4]), .a(a), .b(b),
        .i_last(i_last), .o_valid(ov[4]), .o_ready(o_ready), .o(o_4), .o_overflow(of[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]       f;
        logic [4:0][23:0] v;
    } res_t;

    res_t   q[$];
    int     n_checks = 0;
    int     n_fails  = 0;
    bit     as_cfg [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bit     bs_cfg [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int     w_cfg  [5] = '{24, 24, 24, 16, 16};
    longint macc   [5];
    bit     movf   [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 5; k++) begin
            macc[k] = 0;
            movf[k] = 1'b0;
        end
    endtask

    // Exact integer arithmetic, then range test for overflow and wrap.
    task automatic model_beat(input logic [7:0] av, input logic [7:0] bv, input logic last);
        res_t   nr;
        longint ai, bi, s, m, hi, lo;
        nr = '0;
        for (int k = 0; k < 5; k++) begin
            ai = longint'(av);
            bi = longint'(bv);
            if (as_cfg[k] && av[7]) ai -= 256;
            if (bs_cfg[k] && bv[7]) bi -= 256;
            m  = longint'(1) <<< w_cfg[k];
            s  = macc[k] + ai * bi;
            if (as_cfg[k] || bs_cfg[k]) begin
                hi = m / 2 - 1;
                lo = -(m / 2);
                if (s > hi || s < lo) movf[k] = 1'b1;
                s = s & (m - 1);
                if (s > hi) s -= m;
            end else begin
                if (s >= m) movf[k] = 1'b1;
                s = s & (m - 1);
            end
            if (last) begin
                nr.v[k] = 24'(s & (m - 1));
                nr.f[k] = movf[k];
                macc[k] = 0;
                movf[k] = 1'b0;
            end else begin
                macc[k] = s;
            end
        end
        if (last) q.push_back(nr);
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic last);
        bit got;
        int n;
        got     = 1'b0;
        n       = 0;
        i_valid = 1'b1;
        a       = av;
        b       = bv;
        i_last  = last;
        while (!got && n < 100) begin
            @(negedge clk);
            got = ir[0];
            @(posedge clk);
            #1;
            n++;
        end
        chk("beat_accepted", 32'(got), 32'd1);
        if (got) model_beat(av, bv, last);
        $display("beat a=0x%02h b=0x%02h last=%0d accepted=%0d", av, bv, last, got);
        i_valid = 1'b0;
        i_last  = 1'($urandom);
        a       = 8'($urandom);
        b       = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || ov[0]) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(q.size() == 0 && !ov[0]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 5; k++) begin
            chk({tag, "_o_valid"}, 32'(ov[k]), 32'd0);
            chk({tag, "_o"}, 32'(obs_o[k]), 32'd0);
            chk({tag, "_o_overflow"}, 32'(of[k]), 32'd0);
        end
        chk({tag, "_i_ready"}, 32'(ir[0]), 32'd1);
    endtask

    // Output monitor: scoreboard pop on handshake, hold check during stall,
    // ready/valid relationship every cycle.
    initial begin
        bit          prev_stall;
        logic [23:0] prev_o;
        logic        prev_f;
        res_t        r;
        prev_stall = 1'b0;
        prev_o     = '0;
        prev_f     = 1'b0;
        forever begin
            @(negedge clk);
            if (arst) begin
                prev_stall = 1'b0;
            end else begin
                chk("i_ready", 32'(ir[0]), 32'(!ov[0] || o_ready));
                chk("valid_agree", 32'(ov), 32'({5{ov[0]}}));
                if (prev_stall) begin
                    chk("hold_o", 32'(obs_o[0]), 32'(prev_o));
                    chk("hold_ovf", 32'(of[0]), 32'(prev_f));
                    chk("hold_valid", 32'(ov[0]), 32'd1);
                end
                if (ov[0] && o_ready) begin
                    chk("result_expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        r = q.pop_front();
                        for (int k = 0; k < 5; k++) begin
                            chk($sformatf("o[%0d]", k), 32'(obs_o[k]), 32'(r.v[k]));
                            chk($sformatf("o_overflow[%0d]", k), 32'(of[k]), 32'(r.f[k]));
                        end
                        $display("result o0=0x%06h o3=0x%06h ovf=%05b exp0=0x%06h exp3=0x%06h expovf=%05b",
                                 obs_o[0], obs_o[3], of, r.v[0], r.v[3], r.f);
                    end
                end
                prev_stall = ov[0] && !o_ready;
                prev_o     = obs_o[0];
                prev_f     = of[0];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        arst    = 1'b1;
        i_valid = 1'b0;
        a       = '0;
        b       = '0;
        i_last  = 1'b0;
        o_ready = 1'b1;
        model_clear();
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #3 arst = 1'b0;
        @(posedge clk);
        #1;

        // Basic packet plus last-beat-to-result latency.
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        @(negedge clk);
        chk("latency_edge_k", 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("latency_edge_k1", 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("latency_edge_k2", 32'(ov[0]), 32'd1);
        drain();

        // Signed corners and mixed mode.
        send(8'h80, 8'h80, 1'b0);
        send(8'hFF, 8'h7F, 1'b1);
        drain();
        send(8'hFF, 8'hFF, 1'b1);
        drain();

        // Overflow in the 16-bit accumulators, then a clean single beat.
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        drain();
        send(8'd1, 8'd1, 1'b1);
        drain();

        // Backpressure: first result stalls, remaining results complete back to back.
        o_ready = 1'b0;
        send(8'd10, 8'd3, 1'b1);
        send(8'h90, 8'd2, 1'b1);
        send(8'd7, 8'hF0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_i_ready", 32'(ir[0]), 32'd0);
            chk("stall_o_valid", 32'(ov[0]), 32'd1);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        send(8'hC8, 8'hC8, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("continuous_valid", 32'(ov[0]), 32'd1);
        end
        drain();

        // Bubbles carry garbage operands and a random last bit.
        send(8'd2, 8'd2, 1'b0);
        repeat (2) begin
            a      = 8'($urandom);
            b      = 8'($urandom);
            i_last = 1'($urandom);
            @(posedge clk);
            #1;
        end
        send(8'd3, 8'd3, 1'b0);
        send(8'd1, 8'd1, 1'b1);
        drain();

        // Reset mid-packet with a result pending.
        o_ready = 1'b0;
        send(8'd4, 8'd4, 1'b1);
        send(8'd2, 8'd3, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_valid", 32'(ov[0]), 32'd1);
        @(posedge clk);
        #3 arst = 1'b1;
        #1;
        q.delete();
        model_clear();
        o_ready = 1'b1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        #2 arst = 1'b0;
        @(posedge clk);
        #1;
        send(8'd2, 8'd5, 1'b1);
        drain();

        // Random packets.
        repeat (40) begin
            send(8'($urandom), 8'($urandom), 1'(($urandom % 4) == 0));
            if (($urandom % 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        send(8'($urandom), 8'($urandom), 1'b1);
        drain();

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
